isp_win3x3: RTL and testbench

//  Downstream neighbour of the RGB->gray CSC stage. Consumes the 8-bit gray pixel stream in raster order.

---
 rtl/isp_pkg.sv | 15 +
 rtl/isp_line_ram.sv | 24 ++
 rtl/isp_win3x3.sv | 123 ++++++++++++
 tb/tb_isp_win3x3.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
// Shared pixel and 3x3 window types for the ISP gray-domain stages.
package isp_pkg;

    localparam int unsigned PIX_W = 8;

    typedef logic [PIX_W-1:0] pix_t;

    // Field order matches data_s_win: p00 in the MSBs, row 0 = oldest line.
    typedef struct packed {
        pix_t p00, p01, p02;
        pix_t p10, p11, p12;
        pix_t p20, p21, p22;
    } win3x3_t;

endpackage

// File: rtl/isp_line_ram.sv
// Single line store: asynchronous read, synchronous write at the same address.
module isp_line_ram #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/isp_win3x3.sv
// 3x3 neighbourhood generator: two line buffers plus column shift registers,
// one registered window per interior pixel, valid/ready on both sides.
module isp_win3x3 #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned PIX_W = isp_pkg::PIX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIX_W-1:0]   data_m_gray,
    input  logic               sof_m,
    input  logic               valid_m,
    output logic               ready_m,
    input  logic               ready_s,
    output logic               valid_s,
    output logic [9*PIX_W-1:0] data_s_win,
    output logic               sof_s,
    output logic               eol_s,
    output logic               eof_s
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam int unsigned CW = 3 * PIX_W;

    logic              accept;
    logic              emit;
    logic [XW-1:0]     x_q, x_d, px;
    logic [YW-1:0]     y_q, y_d, py;
    logic [PIX_W-1:0]  lb0_rd, lb1_rd;
    logic [CW-1:0]     col_new;
    logic [CW-1:0]     cola_q, colb_q;
    logic [9*PIX_W-1:0] win_d, win_q;
    logic              valid_q, sof_q, eol_q, eof_q;

    assign ready_m = ~valid_q | ready_s;
    assign accept  = valid_m & ready_m;

    // sof_m relabels the current pixel as (0,0) regardless of the counters.
    assign px = sof_m ? '0 : x_q;
    assign py = sof_m ? '0 : y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (px == X_LAST) begin
            x_d = '0;
            y_d = (py == Y_LAST) ? '0 : py + YW'(1);
        end else begin
            x_d = px + XW'(1);
            y_d = py;
        end
    end

    isp_line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(XW)) u_lb0 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (px),
        .wdata_i (data_m_gray),
        .rdata_o (lb0_rd)
    );

    isp_line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(XW)) u_lb1 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (px),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    // Column layout {row0, row1, row2}; the oldest column register is folded
    // away because the post-shift window is {cola_q, colb_q, col_new}.
    assign col_new = {lb1_rd, lb0_rd, data_m_gray};

    assign win_d = {cola_q[CW-1 -: PIX_W], colb_q[CW-1 -: PIX_W], col_new[CW-1 -: PIX_W],
                    cola_q[2*PIX_W-1 -: PIX_W], colb_q[2*PIX_W-1 -: PIX_W], col_new[2*PIX_W-1 -: PIX_W],
                    cola_q[PIX_W-1:0], colb_q[PIX_W-1:0], col_new[PIX_W-1:0]};

    assign emit = accept && (px >= XW'(2)) && (py >= YW'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            cola_q <= '0;
            colb_q <= '0;
        end else if (accept) begin
            x_q    <= x_d;
            y_q    <= y_d;
            cola_q <= colb_q;
            colb_q <= col_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            win_q   <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else if (accept) begin
            valid_q <= emit;
            if (emit) begin
                win_q <= win_d;
                sof_q <= (px == XW'(2)) && (py == YW'(2));
                eol_q <= (px == X_LAST);
                eof_q <= (px == X_LAST) && (py == Y_LAST);
            end
        end else if (ready_s) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_s    = valid_q;
    assign data_s_win = win_q;
    assign sof_s      = sof_q;
    assign eol_s      = eol_q;
    assign eof_s      = eof_q;

endmodule

// File: tb/tb_isp_win3x3.sv
// Scoreboard bench for isp_win3x3 on an 8x6 frame with a 2-D image reference model.
module tb_isp_win3x3;
    import isp_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned H = 6;

    typedef struct {
        logic [71:0] win;
        logic        sof, eol, eof;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_m_gray;
    logic        sof_m, valid_m, ready_m, ready_s, valid_s;
    logic [71:0] data_s_win;
    logic        sof_s, eol_s, eof_s;

    isp_win3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_m_gray (data_m_gray),
        .sof_m       (sof_m),
        .valid_m     (valid_m),
        .ready_m     (ready_m),
        .ready_s     (ready_s),
        .valid_s     (valid_s),
        .data_s_win  (data_s_win),
        .sof_s       (sof_s),
        .eol_s       (eol_s),
        .eof_s       (eof_s)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    exp_t sbq[$];
    logic [7:0] img [H][W];
    int mx = 0, my = 0;
    logic [7:0] pix_cnt = 8'd0;
    int acc_cnt = 0, nwin = 0, neol = 0, neof = 0, cyc = 0, cyc18 = -100;
    bit chk_first = 1'b0;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [71:0] mkwin(input logic [7:0] b);
        win3x3_t w;
        w.p00 = b;      w.p01 = b + 8'd1;  w.p02 = b + 8'd2;
        w.p10 = b + 8'd8;  w.p11 = b + 8'd9;  w.p12 = b + 8'd10;
        w.p20 = b + 8'd16; w.p21 = b + 8'd17; w.p22 = b + 8'd18;
        return w;
    endfunction

    task automatic model_accept(input logic [7:0] d, input logic sof);
        int x, y;
        exp_t e;
        win3x3_t w;
        x = sof ? 0 : mx;
        y = sof ? 0 : my;
        img[y][x] = d;
        if (x >= 2 && y >= 2) begin
            w.p00 = img[y-2][x-2]; w.p01 = img[y-2][x-1]; w.p02 = img[y-2][x];
            w.p10 = img[y-1][x-2]; w.p11 = img[y-1][x-1]; w.p12 = img[y-1][x];
            w.p20 = img[y][x-2];   w.p21 = img[y][x-1];   w.p22 = img[y][x];
            e.win = w;
            e.sof = (x == 2 && y == 2);
            e.eol = (x == W - 1);
            e.eof = (x == W - 1 && y == H - 1);
            sbq.push_back(e);
        end
        if (x == W - 1) begin
            mx = 0;
            my = (y == H - 1) ? 0 : y + 1;
        end else begin
            mx = x + 1;
            my = y;
        end
    endtask

    task automatic step(input bit vm, input bit rs, input bit sof);
        exp_t e;
        valid_m = vm; ready_s = rs; sof_m = sof; data_m_gray = pix_cnt;
        @(negedge clk);
        if (valid_s && ready_s) begin
            nwin++;
            if (eol_s) neol++;
            if (eof_s) neof++;
            if (sbq.size() == 0) begin
                chk("sb_underflow", 72'(sbq.size()), 72'd1);
            end else begin
                e = sbq.pop_front();
                chk("win", data_s_win, e.win);
                chk("flags", {69'd0, sof_s, eol_s, eof_s}, {69'd0, e.sof, e.eol, e.eof});
            end
            if (chk_first && sof_s) begin
                chk("first_win", data_s_win, mkwin(8'd0));
                chk("sof_latency", 72'(cyc - cyc18), 72'd1);
            end
            if (chk_first && eof_s) chk("eof_win", data_s_win, mkwin(8'd29));
        end
        if (valid_m && ready_m) begin
            if (chk_first && data_m_gray == 8'd18) cyc18 = cyc;
            model_accept(data_m_gray, sof_m);
            acc_cnt++;
            pix_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic stream_to(input int target);
        for (int c = 0; c < 500 && acc_cnt < target; c++) step(1'b1, 1'b1, 1'b0);
        chk("stream_bound", 72'(acc_cnt), 72'(target));
    endtask

    task automatic drain();
        repeat (4) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic new_test();
        pix_cnt = 8'd0; acc_cnt = 0; nwin = 0; neol = 0; neof = 0;
    endtask

    initial begin
        logic [71:0] hold_win;
        logic [2:0]  hold_flg;
        int          rm_low, k_found, acc_before;

        rst_n = 1'b0; valid_m = 1'b0; ready_s = 1'b0; sof_m = 1'b0; data_m_gray = '0;
        #12;
        chk("rst_valid", 72'(valid_s), 72'd0);
        chk("rst_data", data_s_win, 72'd0);
        chk("rst_flags", {69'd0, sof_s, eol_s, eof_s}, 72'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Full-rate streaming
        new_test(); chk_first = 1'b1; rm_low = 0;
        for (int c = 0; c < 48; c++) begin
            step(1'b1, 1'b1, 1'b0);
            if (!ready_m) rm_low++;
        end
        chk("stream_no_stall", 72'(rm_low), 72'd0);
        chk("stream_acc", 72'(acc_cnt), 72'd48);
        drain();
        chk("stream_nwin", 72'(nwin), 72'd24);
        chk("stream_neol", 72'(neol), 72'd4);
        chk("stream_neof", 72'(neof), 72'd1);

        // Backpressure for 5 cycles while a window is pending
        new_test();
        stream_to(20);
        chk("bp_pre_valid", 72'(valid_s), 72'd1);
        hold_win = data_s_win; hold_flg = {sof_s, eol_s, eof_s};
        acc_before = acc_cnt;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("bp_valid", 72'(valid_s), 72'd1);
            chk("bp_data", data_s_win, hold_win);
            chk("bp_flags", 72'({sof_s, eol_s, eof_s}), 72'(hold_flg));
            chk("bp_ready_m", 72'(ready_m), 72'd0);
        end
        chk("bp_no_accept", 72'(acc_cnt), 72'(acc_before));
        stream_to(48);
        drain();
        chk("bp_nwin", 72'(nwin), 72'd24);

        // Random gaps on both sides over 3 frames
        new_test(); chk_first = 1'b0;
        for (int c = 0; c < 3000 && acc_cnt < 144; c++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        chk("rand_acc", 72'(acc_cnt), 72'd144);
        drain();
        chk("rand_nwin", 72'(nwin), 72'd72);
        chk("rand_sb_empty", 72'(sbq.size()), 72'd0);

        // Mid-frame resync on the pixel at (3,4)
        new_test();
        stream_to(35);
        step(1'b1, 1'b1, 1'b1);
        chk("resync_drop", 72'(valid_s), 72'd0);
        nwin = 0; k_found = -1;
        for (int k = 1; k <= 30; k++) begin
            step(1'b1, 1'b1, 1'b0);
            if (valid_s) begin
                k_found = k;
                break;
            end
        end
        chk("resync_gap", 72'(k_found), 72'd18);
        chk("resync_win", data_s_win, mkwin(8'd35));
        stream_to(83);
        drain();
        chk("resync_nwin", 72'(nwin), 72'd24);

        // Asynchronous reset mid-frame with a window pending
        new_test();
        stream_to(20);
        chk("rstmid_pre_valid", 72'(valid_s), 72'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_async_valid", 72'(valid_s), 72'd0);
        sbq.delete(); mx = 0; my = 0;
        @(posedge clk); #1; rst_n = 1'b1;
        new_test(); chk_first = 1'b1;
        stream_to(48);
        drain();
        chk("rstmid_nwin", 72'(nwin), 72'd24);
        chk("rstmid_sb_empty", 72'(sbq.size()), 72'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
